// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline control bundle between the 5-stage datapath and the hazard/stall controller.
// The datapath side (master) supplies hazard information and consumes the register
// enables; the controller side (slave) does the opposite.
interface hazard_stall_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    // Hazard information from the pipeline
    logic [3:0]             IF_ID_Rs;
    logic [3:0]             IF_ID_Rt;
    logic                   IF_ID_Rt_valid;
    logic                   ID_EX_MemRead;
    logic [3:0]             ID_EX_Rd;
    logic                   branch_taken;
    logic                   EX_MEM_MemAccess;
    logic                   dmem_ready;
    logic                   MEM_WB_halt;

    // Pipeline register controls back to the datapath
    logic                   pc_write;
    logic                   if_id_write;
    logic                   if_id_flush;
    logic                   id_ex_write;
    logic                   id_ex_bubble;
    logic                   ex_mem_write;
    logic                   mem_wb_bubble;
    logic                   halted;
    logic                   mem_err;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, IF_ID_Rt_valid, ID_EX_MemRead, ID_EX_Rd,
               branch_taken, EX_MEM_MemAccess, dmem_ready, MEM_WB_halt,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, halted, mem_err, stall_count
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, IF_ID_Rt_valid, ID_EX_MemRead, ID_EX_Rd,
               branch_taken, EX_MEM_MemAccess, dmem_ready, MEM_WB_halt,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_write, mem_wb_bubble, halted, mem_err, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage core.
// Handles load-use stalls, taken-branch flushes, data-memory wait freezes with a
// timeout, and halt. Control outputs are combinational from the registered state
// and the current hazard inputs.
// Optional feature macro: STALL_PERF_CNT_EN -- when defined, stall_count is a
// saturating count of freeze/load-use cycles; otherwise stall_count is tied to 0.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,   // legal range 2..255
    parameter int STALL_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;
    logic       halted_reg;
    logic       mem_err_reg;

    logic       freeze;
    logic       load_use;

    // Hazard detection: memory freeze and load-use dependency (Rd==0 never stalls).
    always_comb begin
        freeze   = bus.EX_MEM_MemAccess & ~bus.dmem_ready;
        load_use = bus.ID_EX_MemRead & (|bus.ID_EX_Rd) &
                   ((bus.ID_EX_Rd == bus.IF_ID_Rs) |
                    (bus.IF_ID_Rt_valid & (bus.ID_EX_Rd == bus.IF_ID_Rt)));
    end

    // Control outputs: reset drain > HALT > freeze > load-use > branch flush > defaults.
    always_comb begin
        bus.pc_write      = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_write   = 1'b1;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_mem_write  = 1'b1;
        bus.mem_wb_bubble = 1'b0;
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.if_id_flush   = 1'b1;
            bus.id_ex_write   = 1'b1;
            bus.id_ex_bubble  = 1'b1;
            bus.ex_mem_write  = 1'b1;
            bus.mem_wb_bubble = 1'b1;
        end else if (state_reg == HALT) begin
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.id_ex_write   = 1'b0;
            bus.ex_mem_write  = 1'b0;
        end else if (freeze) begin
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.id_ex_write   = 1'b0;
            bus.ex_mem_write  = 1'b0;
            bus.mem_wb_bubble = 1'b1;
        end else if (load_use) begin
            // Branch is deliberately ignored here; it re-resolves next cycle.
            bus.pc_write      = 1'b0;
            bus.if_id_write   = 1'b0;
            bus.id_ex_bubble  = 1'b1;
        end else if (bus.branch_taken) begin
            bus.if_id_flush   = 1'b1;
        end
    end

    // Sequencing FSM with memory-wait timeout counter and sticky halt/error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
            halted_reg   <= 1'b0;
            mem_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.MEM_WB_halt) begin
                        state_reg    <= HALT;
                        halted_reg   <= 1'b1;
                        wait_cnt_reg <= 8'd0;
                    end else if (freeze) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.dmem_ready && wait_cnt_reg == TIMEOUT_VAL) begin
                        state_reg    <= HALT;
                        halted_reg   <= 1'b1;
                        mem_err_reg  <= 1'b1;
                        wait_cnt_reg <= 8'd0;
                    end else if (bus.MEM_WB_halt) begin
                        state_reg    <= HALT;
                        halted_reg   <= 1'b1;
                        wait_cnt_reg <= 8'd0;
                    end else if (!bus.dmem_ready) begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end else begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= 8'd0;
                    end
                end
                default: begin
                    // HALT is left only through rst.
                    state_reg  <= HALT;
                    halted_reg <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        bus.halted  = halted_reg;
        bus.mem_err = mem_err_reg;
    end

`ifdef STALL_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    // Saturating count of freeze and load-use cycles; HALT and flush cycles excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (state_reg != HALT && (freeze || load_use) && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.stall_count = stall_cnt_reg;
`else
    assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard testbench for hazard_stall_ctrl: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
    localparam int MEM_TIMEOUT = 8;
    localparam int W           = 6;
    localparam int CNT_MAX     = (1 << W) - 1;

    typedef struct {
        bit       rst;
        bit [3:0] rs;
        bit [3:0] rt;
        bit       rtv;
        bit       mr;
        bit [3:0] rd;
        bit       br;
        bit       ma;
        bit       rdy;
        bit       hlt;
    } in_t;

    typedef struct {
        bit       pc_write;
        bit       if_id_write;
        bit       if_id_flush;
        bit       id_ex_write;
        bit       id_ex_bubble;
        bit       ex_mem_write;
        bit       mem_wb_bubble;
        bit       halted;
        bit       mem_err;
        int       stall_count;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    exp_t exp_q[$];

    // Behavioural model state
    int   m_wait   = 0;   // 0: not waiting; otherwise consecutive wait cycles so far
    bit   m_halt   = 0;
    bit   m_err    = 0;
    int   m_stalls = 0;

    hazard_stall_ctrl_if #(.STALL_CNT_W(W)) bus ();

    hazard_stall_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .STALL_CNT_W (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t i;
        i.rst = 0; i.rs = 0; i.rt = 0; i.rtv = 0; i.mr = 0; i.rd = 0;
        i.br = 0; i.ma = 0; i.rdy = 1; i.hlt = 0;
        return i;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, req);
        end
    endtask

    // Drive one cycle of inputs, push the expected response, advance the model.
    task automatic step(input in_t i);
        exp_t e;
        bit   lu;
        bit   stall;
        bit   timeout;
        @(posedge clk);
        #1;
        rst                  = i.rst;
        bus.IF_ID_Rs         = i.rs;
        bus.IF_ID_Rt         = i.rt;
        bus.IF_ID_Rt_valid   = i.rtv;
        bus.ID_EX_MemRead    = i.mr;
        bus.ID_EX_Rd         = i.rd;
        bus.branch_taken     = i.br;
        bus.EX_MEM_MemAccess = i.ma;
        bus.dmem_ready       = i.rdy;
        bus.MEM_WB_halt      = i.hlt;

        e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 0; e.id_ex_write = 1;
        e.id_ex_bubble = 0; e.ex_mem_write = 1; e.mem_wb_bubble = 0;
        e.halted = m_halt;
        e.mem_err = m_err;
`ifdef STALL_PERF_CNT_EN
        e.stall_count = m_stalls;
`else
        e.stall_count = 0;
`endif
        lu = i.mr && (i.rd != 0) && (i.rd == i.rs || (i.rtv && i.rd == i.rt));
        stall = 0;
        if (i.rst) begin
            e.pc_write = 0; e.if_id_write = 0; e.if_id_flush = 1;
            e.id_ex_bubble = 1; e.mem_wb_bubble = 1;
        end else if (m_halt) begin
            e.pc_write = 0; e.if_id_write = 0; e.id_ex_write = 0; e.ex_mem_write = 0;
        end else if (i.ma && !i.rdy) begin
            e.pc_write = 0; e.if_id_write = 0; e.id_ex_write = 0; e.ex_mem_write = 0;
            e.mem_wb_bubble = 1;
            stall = 1;
        end else if (lu) begin
            e.pc_write = 0; e.if_id_write = 0; e.id_ex_bubble = 1;
            stall = 1;
        end else if (i.br) begin
            e.if_id_flush = 1;
        end
        exp_q.push_back(e);

        if (i.rst) begin
            m_wait = 0; m_halt = 0; m_err = 0; m_stalls = 0;
        end else if (!m_halt) begin
            if (stall && m_stalls < CNT_MAX) m_stalls++;
            timeout = (m_wait > 0) && !i.rdy && (m_wait == MEM_TIMEOUT);
            if (timeout || i.hlt) begin
                m_halt = 1;
                if (timeout) m_err = 1;
                m_wait = 0;
            end else if (m_wait > 0) begin
                m_wait = i.rdy ? 0 : m_wait + 1;
            end else if (i.ma && !i.rdy) begin
                m_wait = 1;
            end
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d: pc_w=%0b ifid_w=%0b ifid_fl=%0b idex_w=%0b idex_bub=%0b exmem_w=%0b memwb_bub=%0b halted=%0b mem_err=%0b cnt=%0d",
                     txn, bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                     bus.id_ex_bubble, bus.ex_mem_write, bus.mem_wb_bubble, bus.halted,
                     bus.mem_err, bus.stall_count);
            check("pc_write",      int'(bus.pc_write),      int'(e.pc_write));
            check("if_id_write",   int'(bus.if_id_write),   int'(e.if_id_write));
            check("if_id_flush",   int'(bus.if_id_flush),   int'(e.if_id_flush));
            check("id_ex_write",   int'(bus.id_ex_write),   int'(e.id_ex_write));
            check("id_ex_bubble",  int'(bus.id_ex_bubble),  int'(e.id_ex_bubble));
            check("ex_mem_write",  int'(bus.ex_mem_write),  int'(e.ex_mem_write));
            check("mem_wb_bubble", int'(bus.mem_wb_bubble), int'(e.mem_wb_bubble));
            check("halted",        int'(bus.halted),        int'(e.halted));
            check("mem_err",       int'(bus.mem_err),       int'(e.mem_err));
            check("stall_count",   int'(bus.stall_count),   e.stall_count);
        end
    end

    initial begin
        in_t i;
        in_t r;
        r = idle();
        r.rst = 1;
        i = idle();
        rst                  = 1'b1;
        bus.IF_ID_Rs         = '0;
        bus.IF_ID_Rt         = '0;
        bus.IF_ID_Rt_valid   = 1'b0;
        bus.ID_EX_MemRead    = 1'b0;
        bus.ID_EX_Rd         = '0;
        bus.branch_taken     = 1'b0;
        bus.EX_MEM_MemAccess = 1'b0;
        bus.dmem_ready       = 1'b1;
        bus.MEM_WB_halt      = 1'b0;
        // Bring registers out of their power-up state before checking begins.
        repeat (2) @(posedge clk);

        step(r);                                        // reset drain outputs
        step(idle());                                   // reset state
        // Load-use, then defaults with stall_count=1
        i = idle(); i.mr = 1; i.rd = 5; i.rs = 5; step(i);
        step(idle());
        // No false stall: Rd=0, and Rt match with Rt_valid=0
        i = idle(); i.mr = 1; i.rd = 0; i.rs = 0; step(i);
        i = idle(); i.mr = 1; i.rd = 7; i.rt = 7; i.rtv = 0; step(i);
        i.rtv = 1; step(i);                             // Rt match counts when valid
        // Branch alone, then branch with load-use
        i = idle(); i.br = 1; step(i);
        i.mr = 1; i.rd = 5; i.rs = 5; step(i);
        step(idle());
        // Memory wait of 3 cycles, released on the 4th
        i = idle(); i.ma = 1; i.rdy = 0;
        repeat (3) step(i);
        i.rdy = 1; step(i);
        step(idle());
        // Halt, then held
        i = idle(); i.hlt = 1; step(i);
        i = idle(); i.br = 1; i.ma = 1; i.rdy = 0; repeat (2) step(i);
        step(r);
        step(idle());
        // Reset during MEM_WAIT
        i = idle(); i.ma = 1; i.rdy = 0; repeat (2) step(i);
        step(r);
        step(idle());
        // Timeout: dmem_ready held low until mem_err
        i = idle(); i.ma = 1; i.rdy = 0; repeat (12) step(i);
        step(idle());
        step(r);
        step(idle());

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            i = idle();
            i.rs  = 4'($urandom_range(0, 7));
            i.rt  = 4'($urandom_range(0, 7));
            i.rd  = 4'($urandom_range(0, 7));
            i.rtv = 1'($urandom_range(0, 1));
            i.mr  = ($urandom_range(0, 2) == 0);
            i.br  = ($urandom_range(0, 3) == 0);
            if (m_wait > 0) begin
                i.ma  = 1;
                i.rdy = ($urandom_range(0, 4) == 0);
            end else begin
                i.ma  = ($urandom_range(0, 3) == 0);
                i.rdy = ($urandom_range(0, 2) != 0);
            end
            i.hlt = ($urandom_range(0, 63) == 0);
            i.rst = ($urandom_range(0, 79) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            step(i);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
